// File: rtl/uart_pkg.sv
// Shared opcode/response bytes and FSM state encoding
// for the UART register responder.
package uart_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        READ,
        RESP,
        DATA,
        NAK
    } state_t;

endpackage

// File: rtl/uart_reg_responder.sv
// Byte-stream register access bridge: 'W'/'R' commands from a UART
// receiver become register strobes, answered with ACK/NAK and read data.
module uart_reg_responder
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_BYTES = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_data_valid,
    output logic                    o_rx_data_ready,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_data_valid,
    input  logic                    i_tx_data_ready,
    output logic [ADDR_WIDTH-1:0]   o_reg_addr,
    output logic [8*DATA_BYTES-1:0] o_reg_wdata,
    output logic                    o_reg_we,
    output logic                    o_reg_re,
    input  logic [8*DATA_BYTES-1:0] i_reg_rdata,
    input  logic                    i_reg_ack
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(DATA_BYTES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

    state_t          state;
    logic            is_read;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rdata_q;
    logic [7:0]      tx_data;
    logic            we;
    logic            re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]   wdata;

    logic rx_fire;
    logic tx_fire;

    function automatic logic [7:0] byte_at(
        input logic [DW-1:0] word,
        input logic [CW-1:0] idx
    );
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (idx == CW'(i)) b = word[8*i +: 8];
        end
        return b;
    endfunction

    assign o_rx_data_ready = (state == IDLE) ||
                             (state == ADDR) ||
                             (state == WDATA);
    assign o_tx_data_valid = (state == RESP) ||
                             (state == DATA) ||
                             (state == NAK);

    assign rx_fire = i_rx_data_valid && o_rx_data_ready;
    assign tx_fire = o_tx_data_valid && i_tx_data_ready;

    assign o_tx_data   = tx_data;
    assign o_reg_we    = we;
    assign o_reg_re    = re;
    assign o_reg_addr  = addr;
    assign o_reg_wdata = wdata;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            is_read <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            tx_data <= '0;
            we      <= 1'b0;
            re      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        if (i_rx_data == OP_WRITE) begin
                            is_read <= 1'b0;
                            state   <= ADDR;
                        end else if (i_rx_data == OP_READ) begin
                            is_read <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            tx_data <= RSP_NAK;
                            state   <= NAK;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr <= ADDR_WIDTH'(i_rx_data);
                        cnt  <= '0;
                        if (is_read) begin
                            re    <= 1'b1;
                            state <= READ;
                        end else begin
                            state <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            if (cnt == CW'(i)) wdata[8*i +: 8] <= i_rx_data;
                        end
                        if (cnt == LAST) begin
                            we    <= 1'b1;
                            state <= WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // the strobe is a single pulse even if ack is slow
                    we <= 1'b0;
                    if (i_reg_ack) begin
                        tx_data <= RSP_ACK;
                        state   <= RESP;
                    end
                end
                READ: begin
                    if (i_reg_ack) begin
                        re      <= 1'b0;
                        rdata_q <= i_reg_rdata;
                        tx_data <= RSP_ACK;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        if (is_read) begin
                            cnt     <= '0;
                            tx_data <= rdata_q[7:0];
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tx_fire) begin
                        if (cnt == LAST) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            tx_data <= byte_at(rdata_q, cnt + 1'b1);
                        end
                    end
                end
                NAK: begin
                    if (tx_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_responder.md
UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, register address width; one address byte on the link.
REQ-002 SHALL have parameter DATA_BYTES, default 4, register width in bytes; register width is 8*DATA_BYTES bits.
REQ-003 SHALL have port i_clock  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_rx_data  input  8  received byte from the UART receive stream.
REQ-006 SHALL have port i_rx_data_valid  input  1  i_rx_data holds a byte.
REQ-007 SHALL have port o_rx_data_ready  output  1  byte accepted when valid and ready are both high.
REQ-008 SHALL have port o_tx_data  output  8  response byte to the UART transmit stream.
REQ-009 SHALL have port o_tx_data_valid  output  1  o_tx_data holds a byte.
REQ-010 SHALL have port i_tx_data_ready  input  1  transmitter takes the byte on valid&&ready.
REQ-011 SHALL have port o_reg_addr  output  ADDR_WIDTH  register address.
REQ-012 SHALL have port o_reg_wdata  output  8*DATA_BYTES  register write data.
REQ-013 SHALL have port o_reg_we  output  1  write strobe, one cycle.
REQ-014 SHALL have port o_reg_re  output  1  read strobe, held until i_reg_ack.
REQ-015 SHALL have port i_reg_rdata  input  8*DATA_BYTES  read data, valid with i_reg_ack.
REQ-016 SHALL have port i_reg_ack  input  1  register access complete.

Function
REQ-017 SHALL implement the FSM states IDLE, ADDR, WDATA, WRITE, READ, RESP, DATA and NAK.
REQ-018 SHALL move from IDLE on opcode byte 0x57 ('W') or 0x52 ('R') to ADDR; on any other byte it SHALL move to NAK.
REQ-019 SHALL, in ADDR, latch the address byte; the next state SHALL be WDATA for 'W' and READ for 'R'.
REQ-020 SHALL, in WDATA, accept DATA_BYTES bytes little-endian into o_reg_wdata and then enter WRITE.
REQ-021 SHALL, in WRITE, pulse o_reg_we high for exactly one cycle and then hold o_reg_we low until i_reg_ack; after ack it SHALL enter RESP.
REQ-022 SHALL, in READ, hold o_reg_re high until i_reg_ack; it SHALL capture i_reg_rdata in the ack cycle and enter RESP.
REQ-023 SHALL, in RESP, present 0x06 (ACK); after the handshake it SHALL enter DATA for a read and IDLE for a write.
REQ-024 SHALL, in DATA, send the captured read word little-endian, DATA_BYTES bytes, and then enter IDLE.
REQ-025 SHALL, in NAK, send 0x15 and then enter IDLE; the offending opcode byte SHALL be consumed.
REQ-026 SHALL drive o_rx_data_ready high only in IDLE, ADDR and WDATA.
REQ-027 SHALL drive o_tx_data_valid high only in RESP, DATA and NAK.
REQ-028 SHALL keep o_tx_data stable while o_tx_data_valid is high and i_tx_data_ready is low.
REQ-029 SHALL make exactly one state transition per handshake; when i_rx_data_valid stays high, back-to-back bytes SHALL be accepted on consecutive cycles.
REQ-030 SHALL count bytes with a counter of width clog2(DATA_BYTES)+1; the counter SHALL clear on entry to WDATA and to DATA.
REQ-031 SHALL ignore i_reg_ack outside WRITE and READ.
REQ-032 SHALL give a minimum 'W' latency of 1 cycle from ack to ACK valid.

Reset
REQ-033 SHALL, on i_reset, go to IDLE asynchronously.
REQ-034 SHALL, on i_reset, clear o_tx_data_valid, o_reg_we and o_reg_re, and set o_reg_addr, o_reg_wdata, o_tx_data and the counter to 0.
REQ-035 SHALL, on reset mid-transaction, abandon the transaction with no response byte and no further strobe.

Structure
REQ-036 SHALL place the opcode constants (0x57, 0x52) and the response constants (0x06, 0x15) in shared package uart_pkg.
REQ-037 SHALL place the FSM state enum in uart_pkg.
REQ-038 SHALL be one flat module with no sub-module; at top level the bench connects it between uart_receive and uart_transmit.

Verification
REQ-039 SHALL cover write: bytes 57,10,EF,BE,AD,DE, ack 2 cycles later -> addr 0x10, wdata 0xDEADBEEF, one we pulse, tx 06.
REQ-040 SHALL cover read: bytes 52,20 with rdata 0x12345678 -> re held until ack, tx 06,78,56,34,12.
REQ-041 SHALL cover a bad opcode: byte 41 -> tx 15, no strobes, next 'R' transaction correct.
REQ-042 SHALL cover backpressure: i_tx_data_ready low for 10 cycles during DATA -> o_tx_data stable and no byte lost.
REQ-043 SHALL cover reset mid-transaction: reset after the 3rd WDATA byte -> IDLE, no we, no tx; a following write completes normally.
REQ-044 SHALL cover back-to-back traffic: 'W' then 'R' with no gap between them -> both respond in order.
